// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared state encodings and constants for the pipeline hazard
//             controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Width of a GPR index (8 registers, r0 reads as zero)
    localparam int PIPE_REG_W = 3;

    localparam logic [15:0] NOP_INSN = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DMISS = 2'd1,
        ST_IMISS = 2'd2,
        ST_MUL   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ============================================================================
//  Module   : hazard_detect
//  Purpose  : Combinational load-use compare between EX destination and ID
//             source registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = PIPE_REG_W
) (
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use  = ex_valid && ex_is_load && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Stall/flush scheduler for the five-stage pipeline with a
//             saturating stall-cycle statistics counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W   = PIPE_REG_W,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_is_mul,
    input  logic             branch_taken,
    input  logic             ic_miss,
    input  logic             ic_ready,
    input  logic             dc_miss,
    input  logic             dc_ready,
    input  logic             stat_clr,
    output logic             pc_we,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    state_t          state_q;
    state_t          state_d;
    logic [MC_W-1:0] mul_cnt;
    logic            mul_load;
    logic            mul_dec;
    logic            load_use;
    logic            if_id_flush_raw;
    logic            id_ex_flush_raw;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .load_use   (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            mul_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (mul_load) begin
                mul_cnt <= MC_W'(MUL_LAT - 2);
            end else if (mul_dec) begin
                mul_cnt <= mul_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_we           = 1'b1;
        if_id_hold      = 1'b0;
        if_id_flush_raw = 1'b0;
        id_ex_hold      = 1'b0;
        id_ex_flush_raw = 1'b0;
        ex_mem_hold     = 1'b0;
        mem_wb_flush    = 1'b0;
        mul_load        = 1'b0;
        mul_dec         = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dc_miss || ex_is_mul) begin
                    pc_we        = 1'b0;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_hold  = 1'b1;
                    mem_wb_flush = 1'b1;
                    if (dc_miss) begin
                        state_d = ST_DMISS;
                    end else begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end
                end else if (branch_taken) begin
                    if_id_flush_raw = 1'b1;
                    id_ex_flush_raw = 1'b1;
                end else if (load_use) begin
                    pc_we           = 1'b0;
                    if_id_hold      = 1'b1;
                    id_ex_flush_raw = 1'b1;
                end else if (ic_miss) begin
                    pc_we           = 1'b0;
                    if_id_flush_raw = 1'b1;
                    state_d         = ST_IMISS;
                end
            end

            ST_DMISS: begin
                pc_we        = 1'b0;
                if_id_hold   = 1'b1;
                id_ex_hold   = 1'b1;
                ex_mem_hold  = 1'b1;
                // Let the refilled load write MEM/WB on the release cycle
                mem_wb_flush = !dc_ready;
                if (dc_ready) begin
                    state_d = ST_RUN;
                end
            end

            ST_MUL: begin
                if (dc_miss || (mul_cnt != '0)) begin
                    pc_we        = 1'b0;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_hold  = 1'b1;
                    mem_wb_flush = 1'b1;
                    if (dc_miss) begin
                        state_d = ST_DMISS;
                    end else begin
                        mul_dec = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_IMISS: begin
                if (dc_miss) begin
                    pc_we        = 1'b0;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_hold  = 1'b1;
                    mem_wb_flush = 1'b1;
                    state_d      = ST_DMISS;
                end else if (branch_taken) begin
                    if_id_flush_raw = 1'b1;
                    id_ex_flush_raw = 1'b1;
                    state_d         = ST_RUN;
                end else if (ic_ready) begin
                    state_d = ST_RUN;
                end else begin
                    pc_we           = 1'b0;
                    if_id_flush_raw = 1'b1;
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    assign if_id_flush = if_id_flush_raw && !if_id_hold;
    assign id_ex_flush = id_ex_flush_raw && !id_ex_hold;
    assign state       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed and randomized self-checking bench for pipe_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int REG_W   = 3;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_is_mul;
    logic             branch_taken, ic_miss, ic_ready, dc_miss, dc_ready, stat_clr;
    logic             pc_we, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
    logic             ex_mem_hold, mem_wb_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    int tests_run;
    int tests_failed;

    // Reference model: mode 0=running,1=dcache wait,2=icache wait,3=multiplying
    int   m_mode;
    int   m_mul_left;
    int   m_cnt;
    int   e_mode_next;
    int   e_mul_next;
    logic [6:0] e_ctl;

    pipe_hazard_ctrl #(
        .REG_W   (REG_W),
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_is_mul    (ex_is_mul),
        .branch_taken (branch_taken),
        .ic_miss      (ic_miss),
        .ic_ready     (ic_ready),
        .dc_miss      (dc_miss),
        .dc_ready     (dc_ready),
        .stat_clr     (stat_clr),
        .pc_we        (pc_we),
        .if_id_hold   (if_id_hold),
        .if_id_flush  (if_id_flush),
        .id_ex_hold   (id_ex_hold),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_hold  (ex_mem_hold),
        .mem_wb_flush (mem_wb_flush),
        .state        (state),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_valid = 0; ex_is_load = 0; ex_is_mul = 0;
        branch_taken = 0; ic_miss = 0; ic_ready = 0; dc_miss = 0; dc_ready = 0; stat_clr = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_mul_left = 0; m_cnt = 0;
    endtask

    // Expected controls packed as {pc_we, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush}
    task automatic model_eval();
        bit lu, stall_pc, hold_all, squash_if, squash_id, drain_wb;
        lu = ex_valid && ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        stall_pc = 0; hold_all = 0; squash_if = 0; squash_id = 0; drain_wb = 0;
        e_mode_next = m_mode;
        e_mul_next  = m_mul_left;
        if (m_mode == 1) begin
            hold_all = 1; drain_wb = !dc_ready;
            if (dc_ready) e_mode_next = 0;
        end else if (dc_miss && m_mode != 0) begin
            hold_all = 1; drain_wb = 1; e_mode_next = 1;
        end else if (m_mode == 3) begin
            if (m_mul_left > 0) begin
                hold_all = 1; drain_wb = 1; e_mul_next = m_mul_left - 1;
            end else e_mode_next = 0;
        end else if (m_mode == 2) begin
            if (branch_taken) begin
                squash_if = 1; squash_id = 1; e_mode_next = 0;
            end else if (ic_ready) e_mode_next = 0;
            else begin
                stall_pc = 1; squash_if = 1;
            end
        end else if (dc_miss) begin
            hold_all = 1; drain_wb = 1; e_mode_next = 1;
        end else if (ex_is_mul) begin
            hold_all = 1; drain_wb = 1; e_mode_next = 3; e_mul_next = MUL_LAT - 2;
        end else if (branch_taken) begin
            squash_if = 1; squash_id = 1;
        end else if (lu) begin
            e_ctl = 7'b0100100;
            return;
        end else if (ic_miss) begin
            stall_pc = 1; squash_if = 1; e_mode_next = 2;
        end
        if (hold_all)
            e_ctl = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, drain_wb};
        else
            e_ctl = {!stall_pc, 1'b0, squash_if, 1'b0, squash_id, 1'b0, 1'b0};
    endtask

    // Inputs are set just after a falling edge; check, then step through one rising edge
    task automatic run_cycle(input string tag);
        #1;
        model_eval();
        chk({tag, ".ctl"}, 32'({pc_we, if_id_hold, if_id_flush, id_ex_hold,
                               id_ex_flush, ex_mem_hold, mem_wb_flush}), 32'(e_ctl));
        chk({tag, ".state"}, 32'(state), 32'(m_mode));
        chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
        @(posedge clk);
        if (stat_clr) m_cnt = 0;
        else if (!e_ctl[6] && m_cnt < CNT_MAX) m_cnt++;
        m_mode     = e_mode_next;
        m_mul_left = e_mul_next;
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        #1;
        chk("reset.pc_we", 32'(pc_we), 32'd1);
        chk("reset.ctl", 32'({if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                              ex_mem_hold, mem_wb_flush}), 32'd0);
        chk("reset.state", 32'(state), 32'd0);
        chk("reset.cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle("idle");

        // Load-use on rs1, then the same pattern against r0
        ex_valid = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        run_cycle("lu_hit");
        ex_rd = 0; id_rs1 = 0;
        run_cycle("lu_r0");
        clear_inputs();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        run_cycle("lu_rs2");
        clear_inputs();
        run_cycle("lu_gone");

        // Multiply: three frozen cycles, released in the fourth
        stat_clr = 1;
        run_cycle("clr");
        clear_inputs();
        ex_is_mul = 1;
        run_cycle("mul1");
        ex_is_mul = 0;
        repeat (3) run_cycle("mul_n");
        chk("mul.stall_cnt", 32'(stall_cnt), 32'd3);
        chk("mul.back_run", 32'(state), 32'd0);

        // D-miss for five cycles, refill on the sixth
        dc_miss = 1;
        repeat (5) run_cycle("dmiss");
        dc_miss = 0; dc_ready = 1;
        chk("dmiss.wb_flush_before", 32'(mem_wb_flush), 32'd1);
        #1;
        chk("dmiss.release_wb", 32'(mem_wb_flush), 32'd0);
        chk("dmiss.release_pc", 32'(pc_we), 32'd0);
        run_cycle("dready");
        dc_ready = 0;
        chk("dmiss.state_run", 32'(state), 32'd0);
        run_cycle("after_dmiss");

        // Branch taken while waiting on the I-cache
        ic_miss = 1;
        run_cycle("imiss_enter");
        ic_miss = 0;
        run_cycle("imiss_wait");
        branch_taken = 1;
        #1;
        chk("imiss_br.ctl", 32'({pc_we, if_id_flush, id_ex_flush}), 32'b111);
        run_cycle("imiss_branch");
        branch_taken = 0;
        chk("imiss_br.state", 32'(state), 32'd0);

        // Asynchronous reset with one frozen multiply cycle still pending
        ex_is_mul = 1;
        run_cycle("mul_a");
        ex_is_mul = 0;
        run_cycle("mul_b");
        chk("mul_mid.frozen", 32'(pc_we), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.state", 32'(state), 32'd0);
        chk("async.pc_we", 32'(pc_we), 32'd1);
        chk("async.hold", 32'(ex_mem_hold), 32'd0);
        chk("async.cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle("post_reset");

        // Counter saturation under a long D-miss
        dc_miss = 1;
        run_cycle("sat_start");
        repeat (CNT_MAX + 8) @(posedge clk);
        @(negedge clk);
        m_cnt = CNT_MAX;
        chk("sat.cnt", 32'(stall_cnt), 32'hFFFF);
        run_cycle("sat_hold");
        dc_miss = 0; dc_ready = 1;
        run_cycle("sat_release");
        dc_ready = 0; stat_clr = 1;
        run_cycle("sat_clr");
        stat_clr = 0;
        chk("sat.cleared", 32'(stall_cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            id_rs1       = REG_W'($urandom_range(0, 7));
            id_rs2       = REG_W'($urandom_range(0, 7));
            ex_rd        = REG_W'($urandom_range(0, 7));
            id_use_rs1   = ($urandom_range(0, 99) < 60);
            id_use_rs2   = ($urandom_range(0, 99) < 50);
            ex_valid     = ($urandom_range(0, 99) < 80);
            ex_is_load   = ($urandom_range(0, 99) < 40);
            ex_is_mul    = ($urandom_range(0, 99) < 8);
            branch_taken = ($urandom_range(0, 99) < 15);
            ic_miss      = ($urandom_range(0, 99) < 15);
            ic_ready     = ($urandom_range(0, 99) < 30);
            dc_miss      = ($urandom_range(0, 99) < 10);
            dc_ready     = ($urandom_range(0, 99) < 30);
            stat_clr     = ($urandom_range(0, 99) < 2);
            run_cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
